// File: rtl/mac_stream_acc_if.sv
// Operand/result stream bundle for mac_stream_acc.
// master = producer of operands and consumer of results; slave = the engine.
interface mac_stream_acc_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic                     last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]         out_len;
    logic                     out_ovf;

    modport master (
        output in_valid, a, b, last, out_ready,
        input  in_ready, out_valid, out_data, out_len, out_ovf
    );

    modport slave (
        input  in_valid, a, b, last, out_ready,
        output in_ready, out_valid, out_data, out_len, out_ovf
    );
endinterface

// File: rtl/mac_stream_acc.sv
// Pipelined signed multiply-accumulate for streamed dot products.
// Pairs enter a MUL_STAGES-deep product pipeline; the tail feeds the accumulator,
// which closes a vector on 'last' and loads a single-entry result slot.
// A held result (out_valid & ~out_ready) freezes the whole engine.
module mac_stream_acc #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int MUL_STAGES = 2,
    parameter bit SATURATE   = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_stream_acc_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    if (ACC_W < PROD_W) begin : g_acc_w_check
        $error("mac_stream_acc: ACC_W must be >= 2*DATA_W");
    end
    if (MUL_STAGES < 1 || MUL_STAGES > 3) begin : g_stages_check
        $error("mac_stream_acc: MUL_STAGES must be 1..3");
    end

    logic                     stall;
    logic                     accept;
    logic signed [PROD_W-1:0] prod_now;

    logic [MUL_STAGES-1:0]              vld_pipe_q,  vld_pipe_d;
    logic [MUL_STAGES-1:0]              last_pipe_q, last_pipe_d;
    logic [MUL_STAGES-1:0][PROD_W-1:0]  prod_pipe_q, prod_pipe_d;

    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0]        out_len_q,   out_len_d;
    logic                    out_ovf_q,   out_ovf_d;

    logic                     tail_vld;
    logic                     tail_last;
    logic signed [PROD_W-1:0] prod_tail;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  sum_raw;
    logic signed [ACC_W-1:0]  sum;
    logic                     ovf_now;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign accept       = bus.in_valid & ~stall;
    assign bus.in_ready = ~stall;

    // Full-width product: both operands widened before the multiply so nothing is lost.
    assign prod_now = PROD_W'(bus.a) * PROD_W'(bus.b);

    assign tail_vld  = vld_pipe_q[MUL_STAGES-1];
    assign tail_last = last_pipe_q[MUL_STAGES-1];
    assign prod_tail = prod_pipe_q[MUL_STAGES-1];
    assign prod_ext  = ACC_W'(prod_tail);

    // Product pipeline: shift one stage per non-stalled edge, hold otherwise.
    always_comb begin
        vld_pipe_d  = vld_pipe_q;
        last_pipe_d = last_pipe_q;
        prod_pipe_d = prod_pipe_q;
        if (!stall) begin
            vld_pipe_d[0]  = accept;
            last_pipe_d[0] = bus.last;
            prod_pipe_d[0] = prod_now;
            for (int i = 1; i < MUL_STAGES; i++) begin
                vld_pipe_d[i]  = vld_pipe_q[i-1];
                last_pipe_d[i] = last_pipe_q[i-1];
                prod_pipe_d[i] = prod_pipe_q[i-1];
            end
        end
    end

    // Adder with signed-overflow detect; clamp toward the sign of the addends when saturating.
    always_comb begin
        acc_base = (state_q == ST_ACCUM) ? acc_q : '0;
        sum_raw  = acc_base + prod_ext;
        ovf_now  = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != acc_base[ACC_W-1]);
        sum      = sum_raw;
        if (SATURATE && ovf_now) begin
            sum = acc_base[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // Accumulator FSM and result slot; a loading result beats a same-edge drain.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        out_ovf_d   = out_ovf_q;
        if (!stall) begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (tail_vld) begin
                if (tail_last) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sum;
                    out_len_d   = cnt_q + CNT_W'(1);
                    out_ovf_d   = ovf_q | ovf_now;
                    state_d     = ST_EMPTY;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    state_d = ST_ACCUM;
                    acc_d   = sum;
                    cnt_d   = cnt_q + CNT_W'(1);
                    ovf_d   = ovf_q | ovf_now;
                end
            end
        end
    end

    // State registers; reset drops the partial sum and every in-flight pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            prod_pipe_q <= '0;
            state_q     <= ST_EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            prod_pipe_q <= prod_pipe_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mac_stream_acc.sv
// Bench for mac_stream_acc: three engines (24-bit saturating, 16-bit saturating,
// 16-bit wrapping) share one stimulus stream. A vector-level model checks every
// cycle; directed tests pin results to hand-computed constants.
module tb_mac_stream_acc;
    localparam int MS = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, last, out_ready;
    logic signed [7:0] a_s, b_s;

    always #5 clk = ~clk;

    mac_stream_acc_if #(.DATA_W(8), .ACC_W(24), .CNT_W(16)) if24 ();
    mac_stream_acc_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) if16s ();
    mac_stream_acc_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) if16w ();

    assign if24.in_valid  = in_valid;  assign if24.a  = a_s; assign if24.b  = b_s;
    assign if24.last      = last;      assign if24.out_ready  = out_ready;
    assign if16s.in_valid = in_valid;  assign if16s.a = a_s; assign if16s.b = b_s;
    assign if16s.last     = last;      assign if16s.out_ready = out_ready;
    assign if16w.in_valid = in_valid;  assign if16w.a = a_s; assign if16w.b = b_s;
    assign if16w.last     = last;      assign if16w.out_ready = out_ready;

    mac_stream_acc #(.DATA_W(8), .ACC_W(24), .MUL_STAGES(MS), .SATURATE(1'b1), .CNT_W(16))
        u_dut24 (.clk(clk), .rst_n(rst_n), .bus(if24));
    mac_stream_acc #(.DATA_W(8), .ACC_W(16), .MUL_STAGES(MS), .SATURATE(1'b1), .CNT_W(16))
        u_dut16s (.clk(clk), .rst_n(rst_n), .bus(if16s));
    mac_stream_acc #(.DATA_W(8), .ACC_W(16), .MUL_STAGES(MS), .SATURATE(1'b0), .CNT_W(16))
        u_dut16w (.clk(clk), .rst_n(rst_n), .bus(if16w));

    typedef struct packed {
        logic [2:0][63:0] d;
        logic [2:0]       o;
        logic [31:0]      len;
        logic [31:0]      cnt;
    } res_t;

    int     chk_cnt  = 0;
    int     pass_cnt = 0;
    int     cyc      = 0;
    int     va[$];
    int     vb[$];
    res_t   pend[$];
    res_t   slot;
    bit     exp_v    = 1'b0;
    res_t   log_q[$];

    logic   obs_v[3], obs_r[3], obs_o[3];
    longint obs_d[3];
    int     obs_l[3];

    task automatic chk(input string nm, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Dot product of the queued vector for an accumulator of width w.
    function automatic void vec_eval(input int w, input bit sat, output longint res, output bit ovf);
        longint acc, mx, mn, s, md;
        md  = longint'(1) << w;
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -(longint'(1) << (w - 1));
        acc = 0;
        ovf = 1'b0;
        foreach (va[i]) begin
            s = acc + longint'(va[i]) * longint'(vb[i]);
            if (s > mx || s < mn) begin
                ovf = 1'b1;
                if (sat) s = (s > mx) ? mx : mn;
                else begin
                    s = s & (md - 1);
                    if (s > mx) s = s - md;
                end
            end
            acc = s;
        end
        res = acc;
    endfunction

    // Per-cycle model check and advance; decisions taken here apply at the next rising edge.
    always @(negedge clk) begin
        bit stall, acc_now, ovf_x;
        longint r;
        res_t nr, le;
        cyc++;
        obs_v[0] = if24.out_valid;  obs_d[0] = longint'(if24.out_data);
        obs_v[1] = if16s.out_valid; obs_d[1] = longint'(if16s.out_data);
        obs_v[2] = if16w.out_valid; obs_d[2] = longint'(if16w.out_data);
        obs_l[0] = int'(if24.out_len); obs_l[1] = int'(if16s.out_len); obs_l[2] = int'(if16w.out_len);
        obs_o[0] = if24.out_ovf; obs_o[1] = if16s.out_ovf; obs_o[2] = if16w.out_ovf;
        obs_r[0] = if24.in_ready; obs_r[1] = if16s.in_ready; obs_r[2] = if16w.in_ready;
        if (!rst_n) begin
            pend.delete(); va.delete(); vb.delete(); exp_v = 1'b0;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rst_valid[%0d]", k), longint'(obs_v[k]), 0);
                chk($sformatf("rst_data[%0d]", k), obs_d[k], 0);
                chk($sformatf("rst_len[%0d]", k), longint'(obs_l[k]), 0);
                chk($sformatf("rst_ovf[%0d]", k), longint'(obs_o[k]), 0);
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("out_valid[%0d]", k), longint'(obs_v[k]), longint'(exp_v));
                if (exp_v) begin
                    chk($sformatf("out_data[%0d]", k), obs_d[k], signed'(slot.d[k]));
                    chk($sformatf("out_len[%0d]", k), longint'(obs_l[k]), longint'(slot.len));
                    chk($sformatf("out_ovf[%0d]", k), longint'(obs_o[k]), longint'(slot.o[k]));
                end
                chk($sformatf("in_ready[%0d]", k), longint'(obs_r[k]), longint'(!(exp_v && !out_ready)));
            end
            if (obs_v[0] && out_ready) begin
                le.d[0] = 64'(obs_d[0]); le.d[1] = 64'(obs_d[1]); le.d[2] = 64'(obs_d[2]);
                le.o = {obs_o[2], obs_o[1], obs_o[0]};
                le.len = 32'(obs_l[0]);
                le.cnt = 32'(cyc);
                log_q.push_back(le);
            end
            stall   = exp_v && !out_ready;
            acc_now = in_valid && !stall;
            if (!stall) begin
                foreach (pend[i]) pend[i].cnt = pend[i].cnt - 1;
                if (pend.size() > 0 && pend[0].cnt == 0) begin
                    slot  = pend.pop_front();
                    exp_v = 1'b1;
                end else if (exp_v && out_ready) begin
                    exp_v = 1'b0;
                end
            end
            if (acc_now) begin
                va.push_back(int'(a_s));
                vb.push_back(int'(b_s));
                if (last) begin
                    vec_eval(24, 1'b1, r, ovf_x); nr.d[0] = 64'(r); nr.o[0] = ovf_x;
                    vec_eval(16, 1'b1, r, ovf_x); nr.d[1] = 64'(r); nr.o[1] = ovf_x;
                    vec_eval(16, 1'b0, r, ovf_x); nr.d[2] = 64'(r); nr.o[2] = ovf_x;
                    nr.len = 32'(va.size());
                    nr.cnt = 32'(MS);
                    pend.push_back(nr);
                    va.delete(); vb.delete();
                end
            end
        end
    end

    // Offer one pair; entered and left just after a rising edge.
    task automatic send(input int av, input int bv, input bit l, output int acyc, output int tries);
        bit ok;
        in_valid = 1'b1; a_s = 8'(av); b_s = 8'(bv); last = l;
        ok = 1'b0; tries = 0; acyc = 0;
        while (!ok && tries < 100) begin
            @(negedge clk);
            ok = if24.in_ready;
            @(posedge clk); #1;
            acyc = cyc;
            tries++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0; last = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int t = 0;
        while (log_q.size() < n && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("log_count", longint'(log_q.size()), longint'(n));
    endtask

    task automatic chk_res(input string nm, input int idx, input longint d24, input longint d16s,
                           input longint d16w, input int len, input bit o24, input bit o16s, input bit o16w);
        if (idx >= log_q.size()) begin
            chk({nm, "_missing"}, longint'(log_q.size()), longint'(idx + 1));
            return;
        end
        chk({nm, "_d24"},  signed'(log_q[idx].d[0]), d24);
        chk({nm, "_d16s"}, signed'(log_q[idx].d[1]), d16s);
        chk({nm, "_d16w"}, signed'(log_q[idx].d[2]), d16w);
        chk({nm, "_len"},  longint'(log_q[idx].len), longint'(len));
        chk({nm, "_ovf24"},  longint'(log_q[idx].o[0]), longint'(o24));
        chk({nm, "_ovf16s"}, longint'(log_q[idx].o[1]), longint'(o16s));
        chk({nm, "_ovf16w"}, longint'(log_q[idx].o[2]), longint'(o16w));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int tc, tr, t1, t2, t3, r1, r2, r3, r4;
        rst_n = 1'b0; in_valid = 1'b0; a_s = '0; b_s = '0; last = 1'b0; out_ready = 1'b1;
        idle(3);
        chk("reset_out_valid", longint'(if24.out_valid), 0);
        chk("reset_out_data",  longint'(if24.out_data), 0);
        rst_n = 1'b1;
        chk("in_ready_after_reset", longint'(if24.in_ready), 1);
        idle(2);

        // 1: 3*4 - 5*6 - 7*8 = -74; visible MS+1 negedges after the accepting one
        send(3, 4, 1'b0, tc, tr); send(-5, 6, 1'b0, tc, tr); send(7, -8, 1'b1, t1, tr);
        wait_log(1);
        chk_res("t1", 0, -74, -74, -74, 3, 0, 0, 0);
        if (log_q.size() > 0) chk("t1_latency", longint'(log_q[0].cnt) - t1, MS + 1);
        log_q.delete(); idle(3);

        // 2: single element -128*-128
        send(-128, -128, 1'b1, t1, tr);
        wait_log(1);
        chk_res("t2", 0, 16384, 16384, 16384, 1, 0, 0, 0);
        log_q.delete(); idle(3);

        // 3: three times 16384: fits in 24 bits, clamps or wraps in 16
        send(-128, -128, 1'b0, tc, tr); send(-128, -128, 1'b0, tc, tr); send(-128, -128, 1'b1, tc, tr);
        wait_log(1);
        chk_res("t3", 0, 49152, 32767, -16384, 3, 0, 1, 1);
        log_q.delete(); idle(3);

        // 4: two vectors while the consumer is blocked
        out_ready = 1'b0;
        send(1, 2, 1'b0, tc, tr); send(3, 4, 1'b1, tc, tr);
        send(5, 6, 1'b0, tc, tr); send(-7, 8, 1'b1, tc, tr);
        idle(5);
        chk("t4_in_ready_held", longint'(if24.in_ready), 0);
        chk("t4_valid_held", longint'(if24.out_valid), 1);
        chk("t4_data_held", longint'(if24.out_data), 14);
        out_ready = 1'b1;
        wait_log(2);
        chk_res("t4a", 0, 14, 14, 14, 2, 0, 0, 0);
        chk_res("t4b", 1, -26, -26, -26, 2, 0, 0, 0);
        log_q.delete(); idle(3);

        // 5: reset in the middle of a 4-element vector
        send(2, 3, 1'b0, tc, tr); send(4, 5, 1'b0, tc, tr);
        rst_n = 1'b0;
        idle(2);
        chk("t5_rst_valid", longint'(if24.out_valid), 0);
        chk("t5_rst_len", longint'(if24.out_len), 0);
        rst_n = 1'b1;
        idle(1);
        send(1, 1, 1'b1, tc, tr);
        wait_log(1);
        idle(6);
        chk("t5_single_result", longint'(log_q.size()), 1);
        chk_res("t5", 0, 1, 1, 1, 1, 0, 0, 0);
        log_q.delete(); idle(3);

        // 6: lengths 1,2,1 back to back with no bubbles
        send(2, 2, 1'b1, t1, r1); send(3, 3, 1'b0, tc, r2);
        send(1, 1, 1'b1, t2, r3); send(-4, 5, 1'b1, t3, r4);
        chk("t6_no_bubble", longint'(r1 + r2 + r3 + r4), 4);
        wait_log(3);
        chk_res("t6a", 0, 4, 4, 4, 1, 0, 0, 0);
        chk_res("t6b", 1, 10, 10, 10, 2, 0, 0, 0);
        chk_res("t6c", 2, -20, -20, -20, 1, 0, 0, 0);
        if (log_q.size() == 3) begin
            chk("t6_lat_a", longint'(log_q[0].cnt) - t1, MS + 1);
            chk("t6_lat_b", longint'(log_q[1].cnt) - t2, MS + 1);
            chk("t6_lat_c", longint'(log_q[2].cnt) - t3, MS + 1);
        end
        log_q.delete(); idle(4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
